// File: rtl/hmmm_pkg.sv
// Shared HMMM definitions: loader FSM states and memory geometry.
package hmmm_pkg;

  localparam int HMMM_ADDR_W    = 8;
  localparam int HMMM_WORD_W    = 16;
  localparam int HMMM_RAM_WORDS = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    FLUSH = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } loader_state_t;

endpackage

// File: rtl/hmmm_program_loader.sv
// Length-prefixed byte-stream loader that writes big-endian words into HMMM RAM.
// Build option: define HMMM_LOADER_CHECKSUM_EN to require a trailing XOR check byte.
//
// state | meaning
// IDLE  | waiting for start, core held
// LEN   | take word-count byte (0 = 256 words)
// HI    | take high byte of next word
// LO    | take low byte, write word next cycle
// FLUSH | final write in flight (no checksum build)
// CHK   | take check byte, compare with XOR of data bytes
// DONE  | image loaded, core released
// ERR   | checksum mismatch, core held
module hmmm_program_loader
  import hmmm_pkg::*;
#(
  parameter int ADDR_W = HMMM_ADDR_W,
  parameter int DATA_W = HMMM_WORD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                core_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     word_count
);

  loader_state_t state, state_next;

  logic [7:0]        hi_byte;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              last_word;

`ifdef HMMM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign accept    = in_valid && in_ready;
  assign last_word = (remaining == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: if (start) state_next = LEN;
      LEN: begin
        in_ready = 1'b1;
        if (in_valid) state_next = HI;
      end
      HI: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LO;
      end
      LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (last_word) begin
`ifdef HMMM_LOADER_CHECKSUM_EN
            state_next = CHK;
`else
            state_next = FLUSH;
`endif
          end else begin
            state_next = HI;
          end
        end
      end
      FLUSH: state_next = DONE;
`ifdef HMMM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (in_data == csum) ? DONE : ERR;
      end
`endif
      DONE: if (start) state_next = LEN;
      ERR:  if (start) state_next = LEN;
      default: state_next = IDLE;
    endcase
  end

  // Write strobe is registered so it lands one cycle after the LO handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_byte    <= '0;
      remaining  <= '0;
      idx        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            idx        <= '0;
            word_count <= '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        LEN: begin
          if (accept)
            remaining <= (in_data == 8'd0) ? (ADDR_W+1)'(HMMM_RAM_WORDS)
                                           : (ADDR_W+1)'(in_data);
        end
        HI: begin
          if (accept) begin
            hi_byte <= in_data;
`ifdef HMMM_LOADER_CHECKSUM_EN
            csum    <= csum ^ in_data;
`endif
          end
        end
        LO: begin
          if (accept) begin
            mem_we     <= 1'b1;
            mem_addr   <= idx;
            mem_wdata  <= {hi_byte, in_data};
            idx        <= idx + ADDR_W'(1);
            word_count <= word_count + (ADDR_W+1)'(1);
            remaining  <= remaining - (ADDR_W+1)'(1);
`ifdef HMMM_LOADER_CHECKSUM_EN
            csum       <= csum ^ in_data;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = (state == DONE);
  assign core_hold = (state != DONE);
`ifdef HMMM_LOADER_CHECKSUM_EN
  assign error     = (state == ERR);
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_hmmm_program_loader.sv
// Self-checking bench for hmmm_program_loader; expected writes come from the byte image itself.
module tb_hmmm_program_loader;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int         n;
    logic [7:0] fill;
    bit         rnd;
    int         vmode;
    bit         poke;
    bit         bad;
    int         exp_wc;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

`ifdef HMMM_LOADER_CHECKSUM_EN
  localparam bit BAD_DONE = 1'b0;
  localparam bit BAD_ERR  = 1'b1;
`else
  localparam bit BAD_DONE = 1'b1;
  localparam bit BAD_ERR  = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [23:0] wlog[$];

  hmmm_program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Capture every RAM write; the core must still be held whenever one happens.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      wlog.push_back({mem_addr, mem_wdata});
      chk("hold_during_we", {31'd0, core_hold}, 32'd1);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    chk({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
    chk({tag, "_mem_addr"},   {24'd0, mem_addr},   32'd0);
    chk({tag, "_mem_wdata"},  {16'd0, mem_wdata},  32'd0);
    chk({tag, "_core_hold"},  {31'd0, core_hold},  32'd1);
    chk({tag, "_done"},       {31'd0, done},       32'd0);
    chk({tag, "_error"},      {31'd0, error},      32'd0);
    chk({tag, "_word_count"}, {23'd0, word_count}, 32'd0);
  endtask

  function automatic bq_t make_image(input int n, input logic [7:0] fill, input bit rnd,
                                     input bit bad);
    bq_t        q;
    int         words;
    logic [7:0] x;
    logic [7:0] b;
    words = (n == 0) ? 256 : n;
    x = 8'h00;
    q.push_back(8'(n));
    for (int i = 0; i < 2 * words; i++) begin
      b = rnd ? 8'($urandom) : fill;
      q.push_back(b);
      x ^= b;
    end
`ifdef HMMM_LOADER_CHECKSUM_EN
    q.push_back(bad ? (x ^ 8'h5A) : x);
`else
    if (bad) x = ~x;
`endif
    return q;
  endfunction

  // Streams one image and checks timing, writes, counters and final status.
  task automatic run_load(input string name, input bq_t img, input int vmode, input bit poke,
                          input int exp_wc, input bit exp_done, input bit exp_err);
    int i;
    int k;
    int budget;
    int bad_cnt;
    bit v;
    bit poked;
    logic [23:0] expw;
    wlog.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_start_hold"}, {31'd0, core_hold}, 32'd1);
    chk({name, "_start_wc"},   {23'd0, word_count}, 32'd0);
    chk({name, "_start_done"}, {31'd0, done}, 32'd0);
    i = 0;
    k = 0;
    poked = 1'b0;
    budget = 8 * img.size() + 64;
    while (i < img.size()) begin
      case (vmode)
        1:       v = (k % 2) == 0;
        2:       v = $urandom_range(0, 1) == 1;
        default: v = 1'b1;
      endcase
      start = 1'b0;
      if (poke && !poked && i == 3) begin
        start = 1'b1;
        poked = 1'b1;
      end
      in_valid = v;
      in_data  = v ? img[i] : 8'hEE;
      if (v && in_ready) i++;
      k++;
      @(negedge clk);
      if (k > budget) begin
        chk({name, "_byte_budget"}, i, img.size());
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
`ifdef HMMM_LOADER_CHECKSUM_EN
    chk({name, "_t1_done"},  {31'd0, done},      {31'd0, exp_done});
    chk({name, "_t1_error"}, {31'd0, error},     {31'd0, exp_err});
    chk({name, "_t1_hold"},  {31'd0, core_hold}, {31'd0, ~exp_done});
    chk({name, "_t1_we"},    {31'd0, mem_we},    32'd0);
`else
    chk({name, "_t1_we"},    {31'd0, mem_we},    32'd1);
    chk({name, "_t1_done"},  {31'd0, done},      32'd0);
    chk({name, "_t1_hold"},  {31'd0, core_hold}, 32'd1);
    @(negedge clk);
    chk({name, "_t2_done"},  {31'd0, done},      {31'd0, exp_done});
    chk({name, "_t2_hold"},  {31'd0, core_hold}, {31'd0, ~exp_done});
    chk({name, "_t2_we"},    {31'd0, mem_we},    32'd0);
`endif
    repeat (3) @(negedge clk);
    chk({name, "_word_count"}, {23'd0, word_count}, exp_wc);
    chk({name, "_n_writes"}, wlog.size(), exp_wc);
    bad_cnt = 0;
    for (int w = 0; w < wlog.size() && w < exp_wc; w++) begin
      expw = {8'(w), img[1 + 2 * w], img[2 + 2 * w]};
      if (wlog[w] !== expw) begin
        if (bad_cnt == 0)
          $display("FAIL %s_write%0d: got %06h, expected %06h", name, w, wlog[w], expw);
        bad_cnt++;
      end
    end
    chk({name, "_write_content"}, bad_cnt, 0);
    chk({name, "_done"},  {31'd0, done},      {31'd0, exp_done});
    chk({name, "_error"}, {31'd0, error},     {31'd0, exp_err});
    chk({name, "_hold"},  {31'd0, core_hold}, {31'd0, ~exp_done});
  endtask

  vec_t tbl[6];
  bq_t  img;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{n: 1,   fill: 8'h3C, rnd: 0, vmode: 0, poke: 0, bad: 0, exp_wc: 1,   exp_done: 1,        exp_err: 0};
    tbl[1] = '{n: 3,   fill: 8'h00, rnd: 1, vmode: 1, poke: 0, bad: 0, exp_wc: 3,   exp_done: 1,        exp_err: 0};
    tbl[2] = '{n: 5,   fill: 8'h00, rnd: 1, vmode: 2, poke: 1, bad: 0, exp_wc: 5,   exp_done: 1,        exp_err: 0};
    tbl[3] = '{n: 0,   fill: 8'hAB, rnd: 0, vmode: 0, poke: 0, bad: 0, exp_wc: 256, exp_done: 1,        exp_err: 0};
    tbl[4] = '{n: 17,  fill: 8'h00, rnd: 1, vmode: 2, poke: 0, bad: 1, exp_wc: 17,  exp_done: BAD_DONE, exp_err: BAD_ERR};
    tbl[5] = '{n: 255, fill: 8'h00, rnd: 1, vmode: 0, poke: 1, bad: 0, exp_wc: 255, exp_done: 1,        exp_err: 0};

    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

    img = {8'h02, 8'h10, 8'h05, 8'h00, 8'h00};
`ifdef HMMM_LOADER_CHECKSUM_EN
    img.push_back(8'h15);
`endif
    run_load("n2", img, 0, 0, 2, 1'b1, 1'b0);
    chk("n2_addr0", {8'd0, wlog[0]}, 32'h00_1005);
    chk("n2_addr1", {8'd0, wlog[1]}, 32'h01_0000);

`ifdef HMMM_LOADER_CHECKSUM_EN
    img = {8'h01, 8'h60, 8'h12, 8'h72};
    run_load("ck_good", img, 0, 0, 1, 1'b1, 1'b0);
    img = {8'h01, 8'h60, 8'h12, 8'h73};
    run_load("ck_bad", img, 0, 0, 1, 1'b0, 1'b1);
    chk("ck_bad_addr0", {8'd0, wlog[0]}, 32'h00_6012);
`else
    img = {8'h01, 8'h60, 8'h12};
    run_load("n1", img, 0, 0, 1, 1'b1, 1'b0);
`endif

    for (int t = 0; t < 6; t++) begin
      img = make_image(tbl[t].n, tbl[t].fill, tbl[t].rnd, tbl[t].bad);
      run_load($sformatf("vec%0d", t), img, tbl[t].vmode, tbl[t].poke,
               tbl[t].exp_wc, tbl[t].exp_done, tbl[t].exp_err);
    end

    // Reset in the middle of a load: len=3 plus three data bytes.
    wlog.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    img = {8'h03, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = img[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_wc", {23'd0, word_count}, 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    img = {8'h01, 8'h60, 8'h12};
`ifdef HMMM_LOADER_CHECKSUM_EN
    img.push_back(8'h72);
`endif
    run_load("reload", img, 0, 0, 1, 1'b1, 1'b0);
    chk("reload_addr0", {8'd0, wlog[0]}, 32'h00_6012);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hmmm_program_loader.md
# hmmm_program_loader

Byte-stream program loader for the HMMM core. It receives a length-prefixed image from a host over a valid/ready byte interface and assembles big-endian 16-bit instruction words. It writes them sequentially into the unified 256-word HMMM RAM through that memory's write port, starting at word 0. It holds the core in reset until the image is fully and correctly written, so a program can be loaded at run time instead of only from the memory's initial image file.

## Interface
Parameters:
- ADDR_W, 8: RAM word-address width (256 words).
- DATA_W, 16: instruction/RAM word width; fixed at 16, and the byte assembly depends on it.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low (0 = in reset).
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- mem_we  output  1  RAM write strobe, one cycle per word.
- mem_addr  output  ADDR_W  RAM word address.
- mem_wdata  output  DATA_W  RAM write data.
- core_hold  output  1  1 = core held in reset.
- done  output  1  level; image loaded and verified.
- error  output  1  level; checksum mismatch.
- word_count  output  ADDR_W+1  number of words written in the current or last load.

## Operation
- States: IDLE, LEN, HI, LO, FLUSH, CHK, DONE, ERR.
- **IDLE:** waits for start, then goes to LEN and clears word_count, done, error and the checksum accumulator.
- **LEN:** accepts 1 byte as the word count N. N=0 means 256 words. Goes to HI.
- **HI:** accepts the high byte, latches it, and goes to LO.
- **LO:** accepts the low byte and goes to the next state:
  - HI if more words remain;
  - FLUSH if this was the last word and checksum is compiled out;
  - CHK if this was the last word and checksum is compiled in.
- **Word write:** on every LO acceptance, the next cycle drives mem_we=1, mem_wdata={hi,lo} and mem_addr=index, and word_count increments in that same cycle.
- **FLUSH:** one cycle, covering the final mem_we. Then goes to DONE.
- **CHK:** accepts 1 byte and compares it to the XOR of all 2N data bytes. The length byte is excluded from the checksum.
  - Match: go to DONE.
  - Mismatch: go to ERR.
- **DONE:** done=1, core_hold=0.
- **ERR:** error=1, core_hold=1.
- in_ready=1 only in LEN, HI, LO and CHK. It is 0 in IDLE, FLUSH, DONE and ERR.
- Address wrap: the word index wraps at 256. N=0 writes addresses 0..255 exactly once.
- start while in LEN/HI/LO/FLUSH/CHK is ignored. start in DONE or ERR restarts the load; core_hold returns to 1 the next cycle.
- Reset mid-load: all outputs return to their reset values immediately and the state goes to IDLE. Words already written stay in RAM.
- On ERR, RAM contains the full image, but the core stays held.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, error=0, word_count=0.
- Byte throughput: one byte per cycle while in_valid stays high. HI and LO are accepted on consecutive cycles with no bubbles between words.
- Write latency: mem_we is asserted exactly 1 cycle after the LO handshake, for exactly 1 cycle.
- Without checksum: last LO accepted at edge T → mem_we high during cycle T+1 (FLUSH) → done=1 and core_hold=0 from cycle T+2.
- With checksum: CHK accepted at edge T → done (or error) from cycle T+1. The final mem_we has already completed by then.
- core_hold never deasserts in the same cycle as a mem_we. The core's first fetch therefore always sees the written RAM.

## Configuration
- Macro HMMM_LOADER_CHECKSUM_EN.
- Defined: the CHK state exists and the trailing checksum byte is required. A mismatch leads to ERR.
- Undefined: no CHK state and no checksum byte. error is tied to 0 and ERR is unreachable.

## Structure
- Shared package hmmm_pkg holds:
  - loader_state_t enum (IDLE..ERR);
  - HMMM_ADDR_W=8;
  - HMMM_WORD_W=16;
  - HMMM_RAM_WORDS=256.
- Single module. The checksum accumulator is an 8-bit register inside the `ifdef`; a separate sub-module is not justified.

## Test plan
- N=2, bytes 0x10,0x05,0x00,0x00, no checksum → writes addr0=0x1005 then addr1=0x0000, word_count=2, done and core_hold=0 two cycles after the last byte.
- With checksum: N=1, bytes 0x60,0x12, check byte 0x72 → done=1, error=0.
- Same as above with check byte 0x73 → error=1, core_hold stays 1, RAM addr0=0x6012.
- in_valid toggled every other cycle, N=3 → no byte is lost or duplicated; mem_we fires exactly 3 times at addresses 0, 1, 2.
- N=0 with 512 bytes of value 0xAB → 256 writes of 0xABAB at addresses 0..255 with no overflow into address 0; word_count=256.
- reset pulled to 0 after 3 data bytes, then released and a full reload of N=1 → outputs at reset values immediately; the reload completes normally with addr0 correct.
